// File: rtl/rb_frame_sequencer.sv
// rb_frame_sequencer: turns a raster pixel stream into row-buffer write/read control and one K-pixel column per accepted pixel after K-1 rows are buffered.
// Latency: RB strobes/addresses are combinational in the accept cycle; the column output is valid one cycle after the accept (aligned with the BRAM read).
// Backpressure: src_ready drops while a held column is not consumed; out_* stay stable until out_ready; start is ignored while busy.
module rb_frame_sequencer #(
  parameter int K       = 3,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int COL_W   = $clog2(IMG_W),
  parameter int ROW_W   = $clog2(IMG_H),
  parameter int RB_ADDR = (K > 2) ? $clog2(K - 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               src_valid,
  output logic               src_ready,
  output logic               wr_en,
  output logic [RB_ADDR-1:0] wr_rb,
  output logic [COL_W-1:0]   wr_col,
  output logic               rd_en,
  output logic [COL_W-1:0]   rd_col,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RB_ADDR-1:0] out_steer,
  output logic [ROW_W-1:0]   out_row,
  output logic [COL_W-1:0]   out_col
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0]   ROW_FILL  = ROW_W'(K - 2);
  // Highest RB index; with K=2 this is 0 so steer never moves.
  localparam logic [RB_ADDR-1:0] STEER_MAX = RB_ADDR'(K - 2);

  state_t             state;
  state_t             state_nxt;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [RB_ADDR-1:0] steer;
  logic               accept;
  logic               stream_rdy;
  logic               last_col;
  logic               last_row;
  logic               fill_row;

  assign accept     = src_valid && src_ready;
  // A new column may be accepted only if the output slot is empty or is being drained now.
  assign stream_rdy = !out_valid || out_ready;
  assign last_col   = (col == COL_LAST);
  assign last_row   = (row == ROW_LAST);
  assign fill_row   = (row == ROW_FILL);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: frame progresses on accepts of the last pixel of a phase
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FILL;
      S_FILL:   if (accept && last_col && fill_row) state_nxt = S_STREAM;
      S_STREAM: if (accept && last_col && last_row) state_nxt = S_DONE;
      S_DONE:   if (!out_valid) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs: handshake, RB strobes and addresses decoded from state and counters
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    src_ready = 1'b0;
    wr_en     = 1'b0;
    wr_rb     = '0;
    wr_col    = '0;
    rd_en     = 1'b0;
    rd_col    = '0;
    case (state)
      S_FILL: begin
        busy      = 1'b1;
        src_ready = 1'b1;
        wr_en     = src_valid;
        wr_rb     = row[RB_ADDR-1:0];
        wr_col    = col;
      end
      S_STREAM: begin
        busy      = 1'b1;
        src_ready = stream_rdy;
        // Same address on both ports: read-first BRAM returns the oldest row before it is overwritten.
        wr_en     = src_valid && stream_rdy;
        rd_en     = src_valid && stream_rdy;
        wr_rb     = steer;
        wr_col    = col;
        rd_col    = col;
      end
      S_DONE: begin
        busy = 1'b1;
        done = !out_valid;
      end
      default: ;
    endcase
  end

  // Pixel position and oldest-RB pointer, advanced per accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      steer <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        col   <= '0;
        row   <= '0;
        steer <= '0;
      end
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + ROW_W'(1);
        if (state == S_STREAM) steer <= (steer == STEER_MAX) ? '0 : steer + RB_ADDR'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Output column register: load on streaming accept, clear once consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_steer <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (accept && state == S_STREAM) begin
      out_valid <= 1'b1;
      out_steer <= steer;
      out_row   <= row;
      out_col   <= col;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rb_frame_sequencer.sv
// Bench for rb_frame_sequencer: randomized handshakes against a pixel-count reference model.
// Timing: inputs driven at negedge, outputs sampled 1ns later, model advances per rising edge.
// Backpressure: exercised through random/forced out_ready and src_valid patterns.
module tb_rb_frame_sequencer;
  localparam int K       = 3;
  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int COL_W   = $clog2(IMG_W);
  localparam int ROW_W   = $clog2(IMG_H);
  localparam int RB_ADDR = (K > 2) ? $clog2(K - 1) : 1;
  localparam int FILL_N  = (K - 1) * IMG_W;
  localparam int TOT     = IMG_H * IMG_W;
  localparam int N_OUT   = (IMG_H - K + 1) * IMG_W;
  localparam int CTL_W   = 6 + RB_ADDR + 2 * COL_W;
  localparam int DAT_W   = RB_ADDR + ROW_W + COL_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               busy;
  logic               done;
  logic               src_valid;
  logic               src_ready;
  logic               wr_en;
  logic [RB_ADDR-1:0] wr_rb;
  logic [COL_W-1:0]   wr_col;
  logic               rd_en;
  logic [COL_W-1:0]   rd_col;
  logic               out_valid;
  logic               out_ready;
  logic [RB_ADDR-1:0] out_steer;
  logic [ROW_W-1:0]   out_row;
  logic [COL_W-1:0]   out_col;

  always #5 clk = ~clk;

  rb_frame_sequencer #(.K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .src_valid(src_valid), .src_ready(src_ready),
    .wr_en(wr_en), .wr_rb(wr_rb), .wr_col(wr_col),
    .rd_en(rd_en), .rd_col(rd_col),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_steer(out_steer), .out_row(out_row), .out_col(out_col)
  );

  logic [CTL_W-1:0] act_ctl;
  logic [DAT_W-1:0] act_dat;
  assign act_ctl = {busy, done, src_ready, wr_en, wr_rb, wr_col, rd_en, rd_col, out_valid};
  assign act_dat = {out_steer, out_row, out_col};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame described by number of accepted pixels so far.
  bit m_busy, m_ov, pend, l_ordy, l_st;
  int m_acc, m_orow, m_ocol, m_osteer;
  bit e_fill, e_stream, e_acc, e_done;
  logic [CTL_W-1:0] exp_ctl;
  logic [DAT_W-1:0] exp_dat;

  task automatic model_reset();
    m_busy = 0; m_ov = 0; pend = 0;
    m_acc = 0; m_orow = 0; m_ocol = 0; m_osteer = 0;
  endtask

  task automatic model_commit();
    if (e_acc) begin
      if (e_stream) begin
        m_ov     = 1;
        m_orow   = m_acc / IMG_W;
        m_ocol   = m_acc % IMG_W;
        m_osteer = (m_orow - (K - 1)) % (K - 1);
      end
      m_acc++;
    end else if (m_ov && l_ordy) begin
      m_ov = 0;
    end
    if (e_done) m_busy = 0;
    else if (!m_busy && l_st) begin
      m_busy = 1;
      m_acc  = 0;
    end
  endtask

  // One clock: advance model past the previous edge, drive inputs, predict outputs.
  task automatic cyc(input bit sv, input bit ordy, input bit st);
    int r, c;
    bit rdy;
    if (pend) model_commit();
    @(negedge clk);
    src_valid = sv; out_ready = ordy; start = st;
    l_ordy = ordy; l_st = st;
    #1;
    r        = m_acc / IMG_W;
    c        = m_acc % IMG_W;
    e_fill   = m_busy && (m_acc < FILL_N);
    e_stream = m_busy && (m_acc >= FILL_N) && (m_acc < TOT);
    rdy      = e_fill || (e_stream && (!m_ov || ordy));
    e_acc    = sv && rdy;
    e_done   = m_busy && (m_acc == TOT) && !m_ov;
    exp_ctl  = {m_busy, e_done, rdy, e_acc,
                RB_ADDR'(e_fill ? r : (e_stream ? (r - (K - 1)) % (K - 1) : 0)),
                COL_W'((e_fill || e_stream) ? c : 0),
                e_acc && e_stream,
                COL_W'(e_stream ? c : 0),
                m_ov};
    exp_dat  = {RB_ADDR'(m_osteer), ROW_W'(m_orow), COL_W'(m_ocol)};
    pend     = 1;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; src_valid = 1; out_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({act_ctl, act_dat} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b want 0", {act_ctl, act_dat});
    end
    @(negedge clk);
    rst = 0;
    cyc(1, 1, 0);
    n_checks++;
    if (act_ctl !== exp_ctl) begin
      n_errors++;
      $display("FAIL reset_idle: got %b want %b", act_ctl, exp_ctl);
    end
  endtask

  task automatic test_full_frame();
    int post = -1, nout = 0, ndone = 0, nwr_pre = 0;
    bit seen_ov = 0;
    for (int i = 0; i < 1000 && post < 3; i++) begin
      cyc(1, 1, i == 0);
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_errors++;
        $display("FAIL full_ctl cycle %0d: got %b want %b", i, act_ctl, exp_ctl);
      end
      if (m_ov) begin
        n_checks++;
        if (act_dat !== exp_dat) begin
          n_errors++;
          $display("FAIL full_col cycle %0d: got %h want %h", i, act_dat, exp_dat);
        end
      end
      if (!seen_ov) begin
        if (out_valid) begin
          seen_ov = 1;
          n_checks++;
          if ({out_row, out_col} !== {ROW_W'(K - 1), COL_W'(0)}) begin
            n_errors++;
            $display("FAIL full_first_col: got row %0d col %0d want row %0d col 0", out_row, out_col, K - 1);
          end
          n_checks++;
          if (nwr_pre !== FILL_N + 1) begin
            n_errors++;
            $display("FAIL full_first_latency: got %0d accepts want %0d", nwr_pre, FILL_N + 1);
          end
        end else if (wr_en) begin
          nwr_pre++;
        end
      end
      if (post == 1) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_errors++;
          $display("FAIL full_busy_drop: got %b want 0", busy);
        end
      end
      if (out_valid && out_ready) nout++;
      if (done) ndone++;
      if (e_done) post = 0;
      else if (post >= 0) post++;
    end
    n_checks++;
    if (post < 3) begin
      n_errors++;
      $display("FAIL full_timeout: got no frame end want done");
    end
    n_checks++;
    if (nout !== N_OUT) begin
      n_errors++;
      $display("FAIL full_out_count: got %0d want %0d", nout, N_OUT);
    end
    n_checks++;
    if (ndone !== 1) begin
      n_errors++;
      $display("FAIL full_done_count: got %0d want 1", ndone);
    end
  endtask

  task automatic test_backpressure();
    int post = -1, nout = 0, ndone = 0, stall_left = 0;
    bit stalled = 0;
    logic [DAT_W-1:0] snap = '0;
    for (int i = 0; i < 1000 && post < 3; i++) begin
      if (!stalled && m_busy && m_acc == 4 * IMG_W + 3) begin
        stalled = 1;
        stall_left = 5;
      end
      cyc(1, stall_left == 0, i == 0);
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_errors++;
        $display("FAIL bp_ctl cycle %0d: got %b want %b", i, act_ctl, exp_ctl);
      end
      if (m_ov) begin
        n_checks++;
        if (act_dat !== exp_dat) begin
          n_errors++;
          $display("FAIL bp_col cycle %0d: got %h want %h", i, act_dat, exp_dat);
        end
      end
      if (stall_left > 0) begin
        if (stall_left == 5) snap = exp_dat;
        n_checks++;
        if ({src_ready, wr_en, out_valid, act_dat} !== {1'b0, 1'b0, 1'b1, snap}) begin
          n_errors++;
          $display("FAIL bp_stall cycle %0d: got rdy %b wr %b vld %b col %h want 0 0 1 %h",
                   i, src_ready, wr_en, out_valid, act_dat, snap);
        end
        stall_left--;
      end
      if (out_valid && out_ready) nout++;
      if (done) ndone++;
      if (e_done) post = 0;
      else if (post >= 0) post++;
    end
    n_checks++;
    if (post < 3 || !stalled) begin
      n_errors++;
      $display("FAIL bp_timeout: got post %0d stalled %0d want frame end after stall", post, stalled);
    end
    n_checks++;
    if ({nout, ndone} !== {N_OUT, 1}) begin
      n_errors++;
      $display("FAIL bp_counts: got %0d outputs %0d done want %0d 1", nout, ndone, N_OUT);
    end
  endtask

  task automatic test_valid_toggle();
    int post = -1, nout = 0, ndone = 0, c;
    for (int i = 0; i < 2000 && post < 3; i++) begin
      cyc(i % 2 == 1, $urandom_range(0, 3) != 0, i == 0);
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_errors++;
        $display("FAIL tog_ctl cycle %0d: got %b want %b", i, act_ctl, exp_ctl);
      end
      if (m_ov) begin
        n_checks++;
        if (act_dat !== exp_dat) begin
          n_errors++;
          $display("FAIL tog_col cycle %0d: got %h want %h", i, act_dat, exp_dat);
        end
      end
      if (e_acc && e_stream) begin
        c = m_acc % IMG_W;
        n_checks++;
        if ({rd_en, wr_col, rd_col} !== {1'b1, COL_W'(c), COL_W'(c)}) begin
          n_errors++;
          $display("FAIL tog_addr cycle %0d: got rd_en %b wr %0d rd %0d want 1 %0d %0d",
                   i, rd_en, wr_col, rd_col, c, c);
        end
      end
      if (out_valid && out_ready) nout++;
      if (done) ndone++;
      if (e_done) post = 0;
      else if (post >= 0) post++;
    end
    n_checks++;
    if (post < 3) begin
      n_errors++;
      $display("FAIL tog_timeout: got no frame end want done");
    end
    n_checks++;
    if ({nout, ndone} !== {N_OUT, 1}) begin
      n_errors++;
      $display("FAIL tog_counts: got %0d outputs %0d done want %0d 1", nout, ndone, N_OUT);
    end
  endtask

  task automatic test_start_ignored();
    int post = -1, nout = 0, ndone = 0;
    bit pulsed = 0, st;
    for (int i = 0; i < 1000 && post < 3; i++) begin
      st = (i == 0);
      if (!pulsed && m_busy && m_acc == 3 * IMG_W) begin
        st = 1;
        pulsed = 1;
      end
      cyc(1, $urandom_range(0, 1) == 1, st);
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_errors++;
        $display("FAIL start_ctl cycle %0d: got %b want %b", i, act_ctl, exp_ctl);
      end
      if (m_ov) begin
        n_checks++;
        if (act_dat !== exp_dat) begin
          n_errors++;
          $display("FAIL start_col cycle %0d: got %h want %h", i, act_dat, exp_dat);
        end
      end
      if (out_valid && out_ready) nout++;
      if (done) ndone++;
      if (e_done) post = 0;
      else if (post >= 0) post++;
    end
    n_checks++;
    if (post < 3 || !pulsed) begin
      n_errors++;
      $display("FAIL start_timeout: got post %0d pulsed %0d want frame end", post, pulsed);
    end
    n_checks++;
    if ({nout, ndone} !== {N_OUT, 1}) begin
      n_errors++;
      $display("FAIL start_counts: got %0d outputs %0d done want %0d 1", nout, ndone, N_OUT);
    end
  endtask

  task automatic test_reset_abort();
    int post = -1, nout = 0, ndone = 0;
    bit hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, i == 0);
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_errors++;
        $display("FAIL abort_pre_ctl cycle %0d: got %b want %b", i, act_ctl, exp_ctl);
      end
      if (m_busy && m_acc == 5 * IMG_W + 3) hit = 1;
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL abort_timeout: got no row 5 col 3 want reached");
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if ({act_ctl, act_dat} !== '0) begin
      n_errors++;
      $display("FAIL abort_outputs: got %b want 0", {act_ctl, act_dat});
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 2000 && post < 3; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, i == 0);
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_errors++;
        $display("FAIL abort_ctl cycle %0d: got %b want %b", i, act_ctl, exp_ctl);
      end
      if (m_ov) begin
        n_checks++;
        if (act_dat !== exp_dat) begin
          n_errors++;
          $display("FAIL abort_col cycle %0d: got %h want %h", i, act_dat, exp_dat);
        end
      end
      if (out_valid && out_ready) nout++;
      if (done) ndone++;
      if (e_done) post = 0;
      else if (post >= 0) post++;
    end
    n_checks++;
    if (post < 3) begin
      n_errors++;
      $display("FAIL abort_frame_timeout: got no frame end want done");
    end
    n_checks++;
    if ({nout, ndone} !== {N_OUT, 1}) begin
      n_errors++;
      $display("FAIL abort_counts: got %0d outputs %0d done want %0d 1", nout, ndone, N_OUT);
    end
  endtask

  initial begin
    rst = 1; start = 0; src_valid = 0; out_ready = 0;
    model_reset();
    test_reset();
    test_full_frame();
    test_backpressure();
    test_valid_toggle();
    test_start_ignored();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rb_frame_sequencer.md
# rb_frame_sequencer

Frame-level controller for the BRAM row-buffer (RB) datapath used in neighbourhood image processing. It accepts a raster pixel stream, generates row-buffer write/read enables, column addresses and the steer (oldest-buffer) select, and emits one K-pixel column per accepted pixel once K-1 rows are buffered. It replaces the free-running enable generation with explicit valid/ready handshakes on both sides and a fill/stream/done frame state machine.

## Interface
- K, 3: window height; RB count is K-1 (K >= 2)
- IMG_W, 8: pixels per row
- IMG_H, 8: rows per frame (IMG_H >= K)
- COL_W, $clog2(IMG_W): column index width
- ROW_W, $clog2(IMG_H): row index width
- RB_ADDR, max(1,$clog2(K-1)): RB select width

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame (sampled in IDLE only)
- busy  out  1  high in FILL/STREAM/DONE
- done  out  1  one-cycle pulse at frame end
- src_valid  in  1  input pixel present
- src_ready  out  1  sequencer accepts pixel this cycle
- wr_en  out  1  RB write strobe (= src_valid && src_ready)
- wr_rb  out  RB_ADDR  RB being written
- wr_col  out  COL_W  RB write address
- rd_en  out  1  RB read strobe (all RBs, same address)
- rd_col  out  COL_W  RB read address
- out_valid  out  1  K-pixel column available at datapath output
- out_ready  in  1  downstream consumes column
- out_steer  out  RB_ADDR  oldest-RB select aligned with out_valid
- out_row  out  ROW_W  image row of the newest pixel in the column
- out_col  out  COL_W  image column of the column

## Operation
- Accept = src_valid && src_ready. col counts 0..IMG_W-1 per accept; at wrap, row increments.
- States: IDLE, FILL, STREAM, DONE.
- IDLE: src_ready=0. start -> FILL, col=row=steer=0. start while busy is ignored.
- FILL (rows 0..K-2): src_ready=1; wr_rb=row, wr_col=col, rd_en=0, no output. Accept at col=IMG_W-1, row=K-2 -> STREAM with steer=0.
- STREAM (rows K-1..IMG_H-1): src_ready = !out_valid || out_ready. On accept: wr_en=1, wr_rb=steer, wr_col=col; rd_en=1, rd_col=col (same address; RB BRAM configured read-first, so the oldest row is read before being overwritten).
- steer = index of oldest RB; on accept at col=IMG_W-1 it advances steer+1 mod (K-1). K=2: steer constant 0.
- Output stage: register loaded on accept in STREAM: out_valid<=1, out_steer<=steer, out_row<=row, out_col<=col; cleared when out_valid && out_ready with no new accept.
- Accept of pixel (IMG_H-1, IMG_W-1) -> DONE; src_ready=0 thereafter.
- DONE: waits until the final out_valid is consumed, then done=1 for one cycle and -> IDLE next cycle.

## Timing
- Reset: all outputs 0, state IDLE, counters/steer 0. rst mid-frame aborts immediately; no done pulse.
- wr_en/rd_en/addresses combinational from state, counters and src_valid/out_ready in the accept cycle.
- Latency: pixel accepted at cycle t -> out_valid at t+1 (matches 1-cycle BRAM read).
- Throughput 1 column/cycle with out_ready=1; out_valid holds, with out_* stable, while out_ready=0.
- Simultaneous consume and accept: register reloads, out_valid stays 1.
- Counter wrap: col IMG_W-1 -> 0 with row+1; row never exceeds IMG_H-1.
- Outputs per frame: (IMG_H-K+1)*IMG_W; accepts per frame: IMG_H*IMG_W.

## Test plan
- K=3, 8x8, src_valid=1, out_ready=1, start pulse: 16 writes (wr_rb 0 then 1) with out_valid=0; first out_valid at cycle after 17th accept with out_row=2, out_col=0.
- Same frame: 48 out_valid cycles total; out_steer sequence per row 0,1,0,1,0,1; done pulses once, 1 cycle after last consume; busy drops with done.
- Backpressure: out_ready=0 for 5 cycles mid row 4 -> src_ready=0, no wr_en, out_* stable; resume without lost or duplicated column.
- src_valid toggling 1,0 during FILL/STREAM -> col advances only on accepts; wr_col/rd_col equal in STREAM.
- start asserted at row 3 -> ignored, counters unaffected.
- rst asserted at row 5, col 3 -> all outputs 0 same cycle; new start runs full correct frame (48 outputs).
